// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Latches the decoded control bundle, operands, immediate and register
// addresses for EX. It also detects load-use hazards against the
// instruction in ID. On a hazard it inserts one bubble and freezes PC and
// IF/ID. A redirect flush squashes the incoming instruction, and a
// downstream hold freezes the whole stage. A saturating counter records
// every bubble that is actually inserted.

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // decoded control from ID
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic [1:0]        ALUOp_i,

    // operands, immediate and register addresses from ID
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,

    // pipeline steering
    input  logic              flush_i,
    input  logic              hold_i,

    // registered control toward EX
    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic [1:0]        ALUOp_o,

    // registered data and addresses toward EX
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [REG_AW-1:0] RSaddr_o,
    output logic [REG_AW-1:0] RTaddr_o,
    output logic [REG_AW-1:0] RDaddr_o,

    // status and hazard outputs
    output logic              valid_o,
    output logic              stall_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    logic load_hits_rs;
    logic load_hits_rt;
    logic load_in_ex;
    logic update_en;
    logic clear_ctrl;
    logic take_bubble;
    logic cnt_saturated;

    // The load in EX writes RTaddr_o. Both ID source fields are compared
    // whatever the instruction type, which is conservative. Register $0 can
    // never create a dependency, so it is excluded.
    assign load_in_ex   = MemRead_o & valid_o & (RTaddr_o != REG_ZERO);
    assign load_hits_rs = (RTaddr_o == RSaddr_i);
    assign load_hits_rt = (RTaddr_o == RTaddr_i);
    assign stall_o      = ~rst_i & load_in_ex & (load_hits_rs | load_hits_rt);

    // PC and IF/ID advance only when neither a bubble nor a downstream hold
    // is pending. They stay enabled while reset is asserted.
    assign PCWrite_o   = rst_i | ~(stall_o | hold_i);
    assign IFIDWrite_o = rst_i | ~(stall_o | hold_i);

    // A flush always updates the stage, even during a hold. Otherwise a hold
    // freezes everything. Flush and bubble both zero the control bundle.
    assign update_en     = flush_i | ~hold_i;
    assign clear_ctrl    = flush_i | stall_o;
    assign take_bubble   = ~flush_i & ~hold_i & stall_o;
    assign cnt_saturated = (bubble_cnt_o == CNT_MAX);

    // Control bundle: load from ID, or clear it to form a bubble or squash.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            ALUOp_o    <= 2'b00;
        end else if (update_en) begin
            if (clear_ctrl) begin
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                MemtoReg_o <= 1'b0;
                RegWrite_o <= 1'b0;
                MemWrite_o <= 1'b0;
                MemRead_o  <= 1'b0;
                ALUOp_o    <= 2'b00;
            end else begin
                RegDst_o   <= RegDst_i;
                ALUSrc_o   <= ALUSrc_i;
                MemtoReg_o <= MemtoReg_i;
                RegWrite_o <= RegWrite_i;
                MemWrite_o <= MemWrite_i;
                MemRead_o  <= MemRead_i;
                ALUOp_o    <= ALUOp_i;
            end
        end
    end

    // Data and address fields follow ID whenever the stage updates. Their
    // contents do not matter while the controls are cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RSdata_o <= '0;
            RTdata_o <= '0;
            Imm_o    <= '0;
            RSaddr_o <= '0;
            RTaddr_o <= '0;
            RDaddr_o <= '0;
        end else if (update_en) begin
            RSdata_o <= RSdata_i;
            RTdata_o <= RTdata_i;
            Imm_o    <= Imm_i;
            RSaddr_o <= RSaddr_i;
            RTaddr_o <= RTaddr_i;
            RDaddr_o <= RDaddr_i;
        end
    end

    // EX holds a real instruction only after a normal load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
        end else if (update_en) begin
            valid_o <= ~clear_ctrl;
        end
    end

    // Count only bubbles that are really inserted. The count sticks at the
    // maximum instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
        end else if (take_bubble && !cnt_saturated) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. A second instance with a 2-bit bubble
// counter shares the same stimulus so that saturation can be observed.

module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i, MemRead_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RSdata_i, RTdata_i, Imm_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic        flush_i, hold_i;

    logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RSdata_o, RTdata_o, Imm_o;
    logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
    logic        valid_o, stall_o, PCWrite_o, IFIDWrite_o;
    logic [15:0] bubble_cnt_o;

    logic        s_RegDst_o, s_ALUSrc_o, s_MemtoReg_o, s_RegWrite_o, s_MemWrite_o, s_MemRead_o;
    logic [1:0]  s_ALUOp_o;
    logic [31:0] s_RSdata_o, s_RTdata_o, s_Imm_o;
    logic [4:0]  s_RSaddr_o, s_RTaddr_o, s_RDaddr_o;
    logic        s_valid_o, s_stall_o, s_PCWrite_o, s_IFIDWrite_o;
    logic [1:0]  s_bubble_cnt_o;

    int pass_count = 0;
    int check_count = 0;
    int exp_bubbles = 0;

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Imm_i(Imm_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .ALUOp_o(ALUOp_o), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .Imm_o(Imm_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
        .valid_o(valid_o), .stall_o(stall_o), .PCWrite_o(PCWrite_o),
        .IFIDWrite_o(IFIDWrite_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Imm_i(Imm_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .RegDst_o(s_RegDst_o), .ALUSrc_o(s_ALUSrc_o), .MemtoReg_o(s_MemtoReg_o),
        .RegWrite_o(s_RegWrite_o), .MemWrite_o(s_MemWrite_o), .MemRead_o(s_MemRead_o),
        .ALUOp_o(s_ALUOp_o), .RSdata_o(s_RSdata_o), .RTdata_o(s_RTdata_o), .Imm_o(s_Imm_o),
        .RSaddr_o(s_RSaddr_o), .RTaddr_o(s_RTaddr_o), .RDaddr_o(s_RDaddr_o),
        .valid_o(s_valid_o), .stall_o(s_stall_o), .PCWrite_o(s_PCWrite_o),
        .IFIDWrite_o(s_IFIDWrite_o), .bubble_cnt_o(s_bubble_cnt_o)
    );

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Drive a full ID bundle
    task automatic applyStimulus(input logic regdst, input logic alusrc,
                                 input logic memtoreg, input logic regwrite,
                                 input logic memwrite, input logic memread,
                                 input logic [1:0] aluop, input logic [31:0] rsdata,
                                 input logic [31:0] rtdata, input logic [31:0] imm,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd);
        RegDst_i = regdst; ALUSrc_i = alusrc; MemtoReg_i = memtoreg;
        RegWrite_i = regwrite; MemWrite_i = memwrite; MemRead_i = memread;
        ALUOp_i = aluop; RSdata_i = rsdata; RTdata_i = rtdata; Imm_i = imm;
        RSaddr_i = rs; RTaddr_i = rt; RDaddr_i = rd;
    endtask

    // R-type add rd, rs, rt
    task automatic applyAdd(input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [31:0] a,
                            input logic [31:0] b);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, a, b, 32'h20, rs, rt, rd);
    endtask

    // lw rt, imm(rs)
    task automatic applyLw(input logic [4:0] rt, input logic [4:0] rs);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'd11, 32'd22, 32'd0, rs, rt, 5'd0);
    endtask

    // Advance one clock; sample 1 ns after the edge
    task automatic stepClock();
        @(posedge clk_i);
        #1;
    endtask

    // Check both counters against the bench's own running bubble total
    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cnt"}, {16'd0, bubble_cnt_o}, exp_bubbles);
        checkOutput({tag, "_cnt_sat"}, {30'd0, s_bubble_cnt_o},
                    (exp_bubbles > 3) ? 32'd3 : exp_bubbles);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
        applyAdd(5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

        // Reset state
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_regwrite", RegWrite_o, 0);
        checkOutput("rst_rsdata", RSdata_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_pcwrite", PCWrite_o, 1);
        checkOutput("rst_ifidwrite", IFIDWrite_o, 1);
        checkCounters("rst");
        rst_i = 1'b0;

        // Plain add $3,$1,$2
        applyAdd(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        stepClock();
        checkOutput("add_regdst", RegDst_o, 1);
        checkOutput("add_regwrite", RegWrite_o, 1);
        checkOutput("add_aluop", ALUOp_o, 2);
        checkOutput("add_rsdata", RSdata_o, 5);
        checkOutput("add_rtdata", RTdata_o, 7);
        checkOutput("add_rdaddr", RDaddr_o, 3);
        checkOutput("add_valid", valid_o, 1);
        checkOutput("add_stall", stall_o, 0);

        // Load-use: lw $4,0($1) then add $5,$4,$2
        applyLw(5'd4, 5'd1);
        stepClock();
        checkOutput("lw_memread", MemRead_o, 1);
        checkOutput("lw_rtaddr", RTaddr_o, 4);
        applyAdd(5'd5, 5'd4, 5'd2, 32'd9, 32'd3);
        #1;
        checkOutput("lu_stall", stall_o, 1);
        checkOutput("lu_pcwrite", PCWrite_o, 0);
        checkOutput("lu_ifidwrite", IFIDWrite_o, 0);
        stepClock();
        exp_bubbles++;
        checkOutput("bub_valid", valid_o, 0);
        checkOutput("bub_regwrite", RegWrite_o, 0);
        checkOutput("bub_memread", MemRead_o, 0);
        checkOutput("bub_regdst", RegDst_o, 0);
        checkOutput("bub_stall", stall_o, 0);
        checkOutput("bub_pcwrite", PCWrite_o, 1);
        checkCounters("bub");
        stepClock();
        checkOutput("after_valid", valid_o, 1);
        checkOutput("after_regwrite", RegWrite_o, 1);
        checkOutput("after_rsaddr", RSaddr_o, 4);
        checkOutput("after_rsdata", RSdata_o, 9);
        checkCounters("after");

        // No false hazard on $0
        applyLw(5'd0, 5'd1);
        stepClock();
        applyAdd(5'd5, 5'd0, 5'd2, 32'd1, 32'd2);
        #1;
        checkOutput("zero_stall", stall_o, 0);
        stepClock();
        checkOutput("zero_valid", valid_o, 1);

        // No false hazard on unrelated registers
        applyLw(5'd4, 5'd1);
        stepClock();
        applyAdd(5'd5, 5'd6, 5'd7, 32'd1, 32'd2);
        #1;
        checkOutput("nodep_stall", stall_o, 0);
        checkOutput("nodep_pcwrite", PCWrite_o, 1);
        stepClock();
        checkOutput("nodep_valid", valid_o, 1);
        checkCounters("nodep");

        // RT-side hazard: add $5,$2,$4
        applyLw(5'd4, 5'd1);
        stepClock();
        applyAdd(5'd5, 5'd2, 5'd4, 32'd1, 32'd2);
        #1;
        checkOutput("rtdep_stall", stall_o, 1);

        // Flush beats the bubble; counter untouched
        flush_i = 1'b1;
        stepClock();
        flush_i = 1'b0;
        checkOutput("flush_valid", valid_o, 0);
        checkOutput("flush_regwrite", RegWrite_o, 0);
        checkOutput("flush_memread", MemRead_o, 0);
        checkCounters("flush");

        // Hold for three cycles while ID changes
        applyAdd(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        stepClock();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01,
                          32'd100 + i, 32'd200 + i, 32'd7, 5'd6, 5'd7, 5'd9);
            #1;
            checkOutput("hold_pcwrite", PCWrite_o, 0);
            checkOutput("hold_ifidwrite", IFIDWrite_o, 0);
            stepClock();
            checkOutput("hold_rsdata", RSdata_o, 5);
            checkOutput("hold_regwrite", RegWrite_o, 1);
            checkOutput("hold_memwrite", MemWrite_o, 0);
            checkOutput("hold_valid", valid_o, 1);
        end
        hold_i = 1'b0;
        #1;
        checkOutput("rel_pcwrite", PCWrite_o, 1);
        stepClock();
        checkOutput("rel_rsdata", RSdata_o, 102);
        checkOutput("rel_memwrite", MemWrite_o, 1);
        checkOutput("rel_rdaddr", RDaddr_o, 9);

        // Hold together with a stall: freeze, no count
        applyLw(5'd4, 5'd1);
        stepClock();
        applyAdd(5'd5, 5'd4, 5'd2, 32'd44, 32'd2);
        hold_i = 1'b1;
        #1;
        checkOutput("hs_stall", stall_o, 1);
        stepClock();
        checkOutput("hs_memread", MemRead_o, 1);
        checkOutput("hs_valid", valid_o, 1);
        checkOutput("hs_stall_again", stall_o, 1);
        checkCounters("hs");
        hold_i = 1'b0;
        stepClock();
        exp_bubbles++;
        checkOutput("hs_bub_valid", valid_o, 0);
        checkCounters("hs_bub");
        stepClock();
        checkOutput("hs_load_rsdata", RSdata_o, 44);
        checkOutput("hs_load_valid", valid_o, 1);

        // Five more bubbles: narrow counter must saturate at 3
        for (int i = 0; i < 5; i++) begin
            applyLw(5'd4, 5'd1);
            stepClock();
            applyAdd(5'd5, 5'd4, 5'd2, 32'd60 + i, 32'd2);
            stepClock();
            exp_bubbles++;
            checkCounters("sat");
            stepClock();
            checkOutput("sat_valid", valid_o, 1);
        end

        // Asynchronous reset between edges
        applyAdd(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        stepClock();
        #3;
        rst_i = 1'b1;
        #1;
        exp_bubbles = 0;
        checkOutput("arst_valid", valid_o, 0);
        checkOutput("arst_regwrite", RegWrite_o, 0);
        checkOutput("arst_rsdata", RSdata_o, 0);
        checkOutput("arst_pcwrite", PCWrite_o, 1);
        checkCounters("arst");
        #1;
        rst_i = 1'b0;
        applyAdd(5'd8, 5'd1, 5'd2, 32'd13, 32'd7);
        stepClock();
        checkOutput("post_rst_valid", valid_o, 1);
        checkOutput("post_rst_rsdata", RSdata_o, 13);
        checkOutput("post_rst_rdaddr", RDaddr_o, 8);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the instruction-decode control unit.
- Latches the decoded control bundle, register operands, immediate and register addresses for the EX stage.
- Contains the load-use hazard detector. On a hazard it inserts a bubble and freezes PC and IF/ID.
- Also honours a flush from branch/jump redirect and a hold from later-stage stalls. Counts inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 32, width of register operands and sign-extended immediate
- REG_AW, 5, register-address width
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- RegDst_i  in  1  decoded control from ID
- ALUSrc_i  in  1  decoded control from ID
- MemtoReg_i  in  1  decoded control from ID
- RegWrite_i  in  1  decoded control from ID
- MemWrite_i  in  1  decoded control from ID
- MemRead_i  in  1  decoded control from ID
- ALUOp_i  in  2  decoded control from ID
- RSdata_i  in  DATA_W  register-file read port 1
- RTdata_i  in  DATA_W  register-file read port 2
- Imm_i  in  DATA_W  sign-extended immediate (funct in [5:0])
- RSaddr_i  in  REG_AW  instr[25:21] of the ID instruction
- RTaddr_i  in  REG_AW  instr[20:16]
- RDaddr_i  in  REG_AW  instr[15:11]
- flush_i  in  1  redirect; squash the instruction entering EX
- hold_i  in  1  downstream stall; freeze the whole stage
- RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o  out  1 each  registered controls
- ALUOp_o  out  2  registered control
- RSdata_o, RTdata_o, Imm_o  out  DATA_W  registered data
- RSaddr_o, RTaddr_o, RDaddr_o  out  REG_AW  registered addresses
- valid_o  out  1  EX holds a real instruction
- stall_o  out  1  load-use hazard detected this cycle
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register update enable
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_i=1, asynchronous): every registered output is 0, including valid_o and bubble_cnt_o. PCWrite_o and IFIDWrite_o are 1 and stall_o is 0 while in reset.
- Hazard detection (combinational from registered state and ID inputs):
  - stall_o = MemRead_o & valid_o & (RTaddr_o != 0) & ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i)).
  - The comparison is conservative: both source fields are compared regardless of instruction type.
- Enables: PCWrite_o = IFIDWrite_o = ~(stall_o | hold_i).
- Update priority at each rising edge, highest first:
  1. flush_i=1: all control outputs cleared to 0 and valid_o=0. Data/address fields load from inputs (don't-care). Flush overrides hold.
  2. hold_i=1: all registers keep their values. bubble_cnt_o unchanged.
  3. stall_o=1: bubble. All control outputs cleared to 0 and valid_o=0. Data/address fields load from inputs. bubble_cnt_o increments.
  4. Otherwise: all fields load from inputs and valid_o=1.
- Latency: one cycle from ID inputs to outputs.
- A load-use hazard yields exactly one bubble. The next cycle MemRead_o=0, so stall_o drops and the held ID instruction then loads.
- bubble_cnt_o saturates at 2^CNT_W-1; it never wraps.
- Simultaneous stall_o and flush_i: flush wins, and the counter does not increment.
- Simultaneous stall_o and hold_i: the stage freezes, the counter does not increment, and stall_o re-evaluates next cycle.
- Reset asserted mid-operation clears the stage immediately, without waiting for a clock edge. The first edge after deassertion loads normally.

Test Plan:
- Reset then a plain instruction: `add $3,$1,$2` (RegDst=1, RegWrite=1, ALUOp=10) with RSdata=5, RTdata=7 -> one cycle later RegDst_o=1, RegWrite_o=1, ALUOp_o=10, RSdata_o=5, RTdata_o=7, valid_o=1, stall_o=0.
- Load-use: `lw $4,0($1)` followed by `add $5,$4,$2` -> stall_o=1 and PCWrite_o=IFIDWrite_o=0 for exactly one cycle. EX then holds the bubble (all controls 0, valid_o=0) and bubble_cnt_o=1. On the next edge the add loads with valid_o=1.
- No false hazard: `lw $0,0($1)` followed by `add $5,$0,$2` gives stall_o=0. `lw $4` followed by `add $5,$6,$7` also gives stall_o=0.
- Flush wins: a load-use hazard with flush_i=1 on the same edge -> EX controls 0, valid_o=0, bubble_cnt_o unchanged.
- Hold: set hold_i=1 for 3 cycles while the ID inputs change -> outputs unchanged throughout and PCWrite_o=0. After release, the current ID inputs load.
- Saturation and async reset: with CNT_W=2, force 5 load-use bubbles -> bubble_cnt_o=3. Pulse rst_i between clock edges -> outputs clear immediately.
